// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared definitions for the RV32M divider: operation
//                encodings, FSM state type, datapath width and small helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    localparam int MD_XLEN = 32;

    // Operation select as driven by decode on de2ex_div_op
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Bit 0 of the encoding distinguishes unsigned from signed ops
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Bit 1 of the encoding selects the remainder rather than the quotient
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

    // Conditional two's-complement negation (mod 2^XLEN)
    function automatic logic [MD_XLEN-1:0] neg_if(input logic [MD_XLEN-1:0] x,
                                                  input logic               neg);
        return neg ? -x : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : md_div_step
//  Description : One combinational restoring-division iteration. Shifts the
//                next dividend bit into the partial remainder and subtracts
//                the divisor when it fits.
//  Ports       : rem_in  - partial remainder before this step (XLEN+1 bits)
//                dvd_msb - dividend bit being brought down
//                dsr     - divisor magnitude
//                rem_out - partial remainder after this step
//                q_bit   - quotient bit produced by this step
//  Revision    : 1.0 - initial release
// ============================================================================
module md_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] dsr,
    output logic [XLEN:0]   rem_out,
    output logic            q_bit
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // rem_in[XLEN] is the bit shifted out the top; when set the shifted value
    // is at least 2^(XLEN+1) and therefore always exceeds the divisor.
    assign w_shift = {rem_in[XLEN-1:0], dvd_msb};
    assign w_diff  = w_shift - {1'b0, dsr};
    assign q_bit   = rem_in[XLEN] | (w_shift >= {1'b0, dsr});
    assign rem_out = q_bit ? w_diff : w_shift;

endmodule
`default_nettype wire

// File: rtl/md_divider.sv
`default_nettype none
// ============================================================================
//  Module      : md_divider
//  Description : Iterative RV32M divider (DIV/DIVU/REM/REMU). Restoring
//                algorithm, one quotient bit per cycle, 32 iterations.
//                Divide-by-zero and signed overflow finish in one cycle.
//  Ports       : clk, rstn                 - clock, async active-low reset
//                de2ex_div_start           - division request
//                de2ex_div_op              - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//                de2ex_rd_oprand1_ffout    - dividend
//                de2ex_rd_oprand2_ffout    - divisor
//                ex_flush                  - abort in-flight / requested op
//                div2mem_divvalid          - one-cycle result-valid pulse
//                div2mem_wr_wdata          - result, held until next result
//                div2ex_busy               - pipeline stall request
//  Revision    : 1.0 - initial release
// ============================================================================
module md_divider
    import md_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            de2ex_div_start,
    input  logic [1:0]      de2ex_div_op,
    input  logic [XLEN-1:0] de2ex_rd_oprand1_ffout,
    input  logic [XLEN-1:0] de2ex_rd_oprand2_ffout,
    input  logic            ex_flush,
    output logic            div2mem_divvalid,
    output logic [XLEN-1:0] div2mem_wr_wdata,
    output logic            div2ex_busy
);

    localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [4:0]      C_LAST    = 5'd31;

    div_state_t      r_state;
    div_state_t      w_state_next;
    logic            r_s1;
    logic            r_s2;
    logic            r_is_rem;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_dvd;      // dividend shifts out the top, quotient in at the bottom
    logic [XLEN-1:0] r_dsr;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_busy;
    logic            w_valid;
    logic            w_load_special;
    logic            w_load_calc;
    logic            w_signed;
    logic            w_sign1;
    logic            w_sign2;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_result;
    logic [XLEN:0]   w_rem_next;
    logic            w_q_bit;
    logic [XLEN-1:0] w_quo_next;
    logic [XLEN-1:0] w_calc_result;

    // ---------------------------------------------------------------- decode
    assign w_signed  = op_is_signed(de2ex_div_op);
    assign w_sign1   = w_signed & de2ex_rd_oprand1_ffout[XLEN-1];
    assign w_sign2   = w_signed & de2ex_rd_oprand2_ffout[XLEN-1];
    assign w_div0    = (de2ex_rd_oprand2_ffout == '0);
    assign w_ovf     = w_signed & (de2ex_rd_oprand1_ffout == C_MIN_NEG)
                                & (de2ex_rd_oprand2_ffout == '1);
    assign w_special = w_div0 | w_ovf;

    // Special results bypass the sign fixup: x/0 returns all-ones and x
    // regardless of operand signs.
    always_comb begin
        w_special_result = '0;
        if (op_is_rem(de2ex_div_op)) begin
            w_special_result = w_div0 ? de2ex_rd_oprand1_ffout : '0;
        end else begin
            w_special_result = w_div0 ? '1 : C_MIN_NEG;
        end
    end

    // -------------------------------------------------------------- datapath
    md_div_step #(
        .XLEN    (XLEN)
    ) u_step (
        .rem_in  (r_rem),
        .dvd_msb (r_dvd[XLEN-1]),
        .dsr     (r_dsr),
        .rem_out (w_rem_next),
        .q_bit   (w_q_bit)
    );

    assign w_quo_next    = {r_dvd[XLEN-2:0], w_q_bit};
    // The result register is written on the edge into DONE, so the value is
    // already on div2mem_wr_wdata during the valid cycle.
    assign w_calc_result = r_is_rem ? neg_if(w_rem_next[XLEN-1:0], r_s1)
                                    : neg_if(w_quo_next, r_s1 ^ r_s2);

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_busy         = 1'b0;
        w_valid        = 1'b0;
        w_load_special = 1'b0;
        w_load_calc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (de2ex_div_start && !ex_flush) begin
                    w_accept = 1'b1;
                    w_busy   = 1'b1;
                    if (w_special) begin
                        w_load_special = 1'b1;
                        w_state_next   = DONE;
                    end else begin
                        w_state_next   = CALC;
                    end
                end
            end
            CALC: begin
                w_busy = 1'b1;
                if (ex_flush) begin
                    w_state_next = IDLE;
                end else if (r_cnt == C_LAST) begin
                    w_load_calc  = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                // Pulse is driven even if flushed this cycle
                w_valid      = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_is_rem <= 1'b0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_s1     <= w_sign1;
                r_s2     <= w_sign2;
                r_is_rem <= op_is_rem(de2ex_div_op);
                r_rem    <= '0;
                r_dvd    <= neg_if(de2ex_rd_oprand1_ffout, w_sign1);
                r_dsr    <= neg_if(de2ex_rd_oprand2_ffout, w_sign2);
                r_cnt    <= '0;
            end else if (r_state == CALC) begin
                r_rem    <= w_rem_next;
                r_dvd    <= w_quo_next;
                r_cnt    <= r_cnt + 5'd1;
            end

            if (w_load_special) begin
                r_result <= w_special_result;
            end else if (w_load_calc) begin
                r_result <= w_calc_result;
            end
        end
    end

    assign div2mem_divvalid = w_valid;
    assign div2mem_wr_wdata = r_result;
    assign div2ex_busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_md_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_divider
//  Description : Directed self-checking bench for md_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_divider;
    import md_pkg::*;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        flush = 1'b0;
    logic        valid;
    logic [31:0] wdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    md_divider #(.XLEN(32)) dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .de2ex_div_start        (start),
        .de2ex_div_op           (op),
        .de2ex_rd_oprand1_ffout (a),
        .de2ex_rd_oprand2_ffout (b),
        .ex_flush               (flush),
        .div2mem_divvalid       (valid),
        .div2mem_wr_wdata       (wdata),
        .div2ex_busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Vector tables: op, dividend, divisor, expected result, expected latency
    localparam int NS = 6;
    localparam logic [1:0]  SG_OP  [NS] = '{DIV_OP_DIV, DIV_OP_REM, DIV_OP_REM,
                                            DIV_OP_DIV, DIV_OP_REMU, DIV_OP_DIVU};
    localparam logic [31:0] SG_A   [NS] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                                            32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] SG_B   [NS] = '{32'd2, 32'd2, 32'hFFFF_FFFE,
                                            32'd2, 32'd10, 32'd10};
    localparam logic [31:0] SG_EXP [NS] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                                            32'hC000_0000, 32'd5, 32'h1999_9999};

    localparam int NP = 8;
    localparam logic [1:0]  SP_OP  [NP] = '{DIV_OP_DIV, DIV_OP_REMU, DIV_OP_DIV, DIV_OP_REM,
                                            DIV_OP_DIVU, DIV_OP_DIV, DIV_OP_REM, DIV_OP_DIVU};
    localparam logic [31:0] SP_A   [NP] = '{32'h1234, 32'h1234, 32'hFFFF_EDCC, 32'hFFFF_FFFB,
                                            32'h1234, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    localparam logic [31:0] SP_B   [NP] = '{32'd0, 32'd0, 32'd0, 32'd0,
                                            32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] SP_EXP [NP] = '{32'hFFFF_FFFF, 32'h1234, 32'hFFFF_FFFF, 32'hFFFF_FFFB,
                                            32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd0};
    localparam int          SP_LAT [NP] = '{1, 1, 1, 1, 1, 1, 1, 33};

    // Drive a request in the next cycle and hold it through the accept edge.
    // Returns at edge+1 of the accept edge, i.e. in cycle T+1.
    task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      output logic busy_at_accept);
        @(posedge clk); #1;
        op = o; a = x; b = y; start = 1'b1;
        #1 busy_at_accept = busy;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Latency counted in cycles after the accept edge; busy must stay high
    // until the valid cycle and be low in it.
    task automatic wait_valid(input int max, output int lat, output logic busy_ok);
        lat     = 1;
        busy_ok = 1'b1;
        while (valid !== 1'b1 && lat < max) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (valid === 1'b1 && busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", wdata); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_divu();
        logic ba, bok;
        int   lat;
        go(DIV_OP_DIVU, 32'd100, 32'd7, ba);
        wait_valid(60, lat, bok);
        n_checks++; if (ba !== 1'b1) begin n_fail++; $display("FAIL divu_busy_accept: got %b expected 1", ba); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d expected 33", lat); end
        n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL divu_busy_window: got %b expected 1", bok); end
        n_checks++; if (wdata !== 32'd14) begin n_fail++; $display("FAIL divu_100_7: got %h expected %h", wdata, 32'd14); end
        @(posedge clk); #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL divu_pulse_width: got %b expected 0", valid); end
        n_checks++; if (wdata !== 32'd14) begin n_fail++; $display("FAIL divu_hold: got %h expected %h", wdata, 32'd14); end
        go(DIV_OP_REMU, 32'd100, 32'd7, ba);
        wait_valid(60, lat, bok);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL remu_latency: got %0d expected 33", lat); end
        n_checks++; if (wdata !== 32'd2) begin n_fail++; $display("FAIL remu_100_7: got %h expected %h", wdata, 32'd2); end
    endtask

    task automatic test_signed();
        logic ba, bok;
        int   lat;
        for (int i = 0; i < NS; i++) begin
            go(SG_OP[i], SG_A[i], SG_B[i], ba);
            wait_valid(60, lat, bok);
            n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL signed_latency[%0d]: got %0d expected 33", i, lat); end
            n_checks++; if (wdata !== SG_EXP[i]) begin n_fail++; $display("FAIL signed_result[%0d]: got %h expected %h", i, wdata, SG_EXP[i]); end
        end
    endtask

    task automatic test_special();
        logic ba, bok;
        int   lat;
        for (int i = 0; i < NP; i++) begin
            go(SP_OP[i], SP_A[i], SP_B[i], ba);
            wait_valid(60, lat, bok);
            n_checks++; if (lat !== SP_LAT[i]) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d expected %0d", i, lat, SP_LAT[i]); end
            n_checks++; if (wdata !== SP_EXP[i]) begin n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", i, wdata, SP_EXP[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic ba, bok;
        int   lat;
        go(DIV_OP_DIVU, 32'd100, 32'd7, ba);
        wait_valid(60, lat, bok);
        n_checks++; if (wdata !== 32'd14) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", wdata, 32'd14); end
        // go() drives the next start in the IDLE cycle right after DONE
        go(DIV_OP_DIV, 32'h1234, 32'd0, ba);
        wait_valid(60, lat, bok);
        n_checks++; if (ba !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b expected 1", ba); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 1", lat); end
        n_checks++; if (wdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", wdata, 32'hFFFF_FFFF); end
        go(DIV_OP_REMU, 32'd100, 32'd7, ba);
        wait_valid(60, lat, bok);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_third_latency: got %0d expected 33", lat); end
        n_checks++; if (wdata !== 32'd2) begin n_fail++; $display("FAIL b2b_third: got %h expected %h", wdata, 32'd2); end
    endtask

    // Entered with wdata == 2 from the previous test
    task automatic test_flush();
        logic ba;
        int   seen;
        seen = 0;
        go(DIV_OP_DIVU, 32'd1000, 32'd3, ba);            // now in cycle T+1
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) seen++;
        end
        // T+5: a special-case start that must be ignored while in CALC
        op = DIV_OP_DIV; a = 32'h1234; b = 32'd0; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (valid === 1'b1) seen++;
        end
        // T+10
        flush = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
        @(posedge clk); #1;
        flush = 1'b0;
        // T+11
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got busy %b expected 0", busy); end
        n_checks++; if (wdata !== 32'd2) begin n_fail++; $display("FAIL flush_wdata: got %h expected %h", wdata, 32'd2); end
        for (int i = 0; i < 40; i++) begin
            if (valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_pulse: got %0d pulses expected 0", seen); end
        // Start and flush in the same cycle
        seen = 0;
        op = DIV_OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1; flush = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_idle: got %b expected 0", busy); end
        for (int i = 0; i < 40; i++) begin
            if (valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_start_no_pulse: got %0d pulses expected 0", seen); end
        n_checks++; if (wdata !== 32'd2) begin n_fail++; $display("FAIL flush_start_wdata: got %h expected %h", wdata, 32'd2); end
    endtask

    task automatic test_reset_mid();
        logic ba, bok;
        int   lat;
        go(DIV_OP_DIVU, 32'd100, 32'd7, ba);             // cycle T+1, wdata == 2
        repeat (19) @(posedge clk);                       // cycle T+20
        #2 rstn = 1'b0;
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_checks++; if (wdata !== 32'd0) begin n_fail++; $display("FAIL rst_mid_wdata: got %h expected 0", wdata); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        go(DIV_OP_DIVU, 32'd100, 32'd7, ba);
        wait_valid(60, lat, bok);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL rst_restart_latency: got %0d expected 33", lat); end
        n_checks++; if (wdata !== 32'd14) begin n_fail++; $display("FAIL rst_restart_result: got %h expected %h", wdata, 32'd14); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_divider.md
# md_divider

Iterative RV32M divider that computes DIV/DIVU/REM/REMU results for the execute stage. It takes operands from the decode/execute pipeline registers and returns a one-cycle `div2mem_divvalid` pulse with the 32-bit result on `div2mem_wr_wdata`, which execute muxes into `ex2mem_wr_wdata` when `de2ex_MD_OP_ffout` is set. While a division is in flight it asserts a busy stall toward the pipeline.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `de2ex_div_start` in 1: request a division this cycle. Decode drives it as MD_OP & div-class & inst_valid.
- `de2ex_div_op` in 2: operation select. 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
- `de2ex_rd_oprand1_ffout` in 32: dividend.
- `de2ex_rd_oprand2_ffout` in 32: divisor.
- `ex_flush` in 1: abort any in-flight or requested division.
- `div2mem_divvalid` out 1: result-valid pulse.
- `div2mem_wr_wdata` out 32: result; held stable until the next accepted start.
- `div2ex_busy` out 1: pipeline stall request.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `de2ex_div_start=1` with `ex_flush=0` is accepted.
  - The block latches the op, the signs s1 = op1[31] and s2 = op2[31] (signed ops only, else 0), and the magnitudes |op1| and |op2|.
  - It clears the 33-bit partial remainder and the 5-bit counter.
  - Special cases go straight to DONE with a preset result:
    - divisor==0: quotient=32'hFFFF_FFFF, remainder=op1.
    - Signed op with op1=32'h8000_0000 and op2=32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0.
  - Otherwise the next state is CALC.
- CALC: one restoring step per cycle, MSB of the dividend first.
  - rem' = {rem[31:0], dvd[31]}.
  - If rem' >= {1'b0, dsr}, subtract and shift in quotient bit 1; else keep rem' and shift in 0.
  - The counter increments. After the step with counter==31, the next state is DONE (exactly 32 CALC cycles).
- DONE:
  - Load the result register:
    - DIV/DIVU: quotient, negated if s1^s2.
    - REM/REMU: remainder[31:0], negated if s1.
  - `div2mem_divvalid`=1 for this cycle only. The next state is IDLE.
- `de2ex_div_start` is ignored in CALC and DONE; there is no queueing.
- `ex_flush`:
  - In any state, the next state is IDLE and no valid pulse is produced.
  - The result register keeps its previous value.
  - Flush in the same cycle as start: flush wins and nothing is accepted.
  - Flush during DONE: the valid pulse in that cycle is still driven, but the next state is IDLE.
- `div2ex_busy` = start-accept condition in IDLE | (state==CALC) | (state==DONE & ~... ) — it is high from the accept cycle through the cycle before DONE, and low in DONE so execute advances with the result.
- Arithmetic:
  - Magnitude = two's-complement negate when the sign bit is set.
  - Negation is mod 2^32, so |0x8000_0000| = 0x8000_0000 as unsigned, which is correct.
  - The remainder datapath is 33 bits; the quotient is 32 bits.

## Timing
- Reset values: state=IDLE, counter=0, `div2mem_divvalid`=0, `div2mem_wr_wdata`=0, `div2ex_busy`=0.
- Normal latency: start accepted at edge T → CALC on cycles T+1..T+32 → DONE (valid high) on cycle T+33.
- Special-case latency: DONE on cycle T+1.
- Back-to-back: a new start can be accepted in the IDLE cycle immediately after DONE.
- Reset asserted mid-operation: the block returns immediately to the reset values with no pulse.

## Structure
- Shared package `md_pkg` holds:
  - Div op encodings `DIV_OP_DIV`/`DIVU`/`REM`/`REMU`.
  - State enum `div_state_t` {IDLE, CALC, DONE}.
  - `MD_XLEN`=32.
- One natural sub-module is `md_div_step`: the combinational single restoring iteration (rem_in, dvd_msb, dsr → rem_out, q_bit). It is instantiated once.

## Test plan
- DIVU 100/7 → pulse on cycle T+33 with 14. REMU with the same operands → 2. Busy is high for cycles T..T+32.
- DIV −7/2 → 0xFFFF_FFFD (−3). REM −7/2 → 0xFFFF_FFFF (−1). REM 7/−2 → 1.
- DIV x/0 (x=0x1234) → 0xFFFF_FFFF at T+1. REMU x/0 → 0x1234.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000 at T+1. REM with the same operands → 0. DIVU with the same operands → 0 after 33 cycles.
- Flush at T+10 → no pulse, IDLE at T+11, previous wdata is unchanged. A start asserted at T+5 is ignored. Start with flush in the same cycle → nothing accepted.
- Drop `rstn` at T+20 → all outputs are 0 immediately. A restart after release completes normally.
